frame_writer: RTL and testbench

Capture-side counterpart of the display path: accepts a push-only 24-bit pixel stream, packs eight pixels into each 256-bit memory word and writes whole frames to external memory starting at a programmable base address. It uses the same word-wide memory request interface the display path reads through (valid / ready / rw / addr / data, last_addr_update), with rw driven for writes, so a captured frame can be read back by the display path unchanged.

---
 rtl/frame_wr_pkg.sv | 26 ++
 rtl/frame_wr_if.sv | 31 +++
 rtl/frame_wr_fifo.sv | 48 ++++
 rtl/frame_writer.sv | 170 +++++++++++++++++
 tb/tb_frame_writer.sv | 396 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_wr_pkg.sv
// Shared types and widths for the frame capture writer.
// Optional FRAME_WR_DROP_CNT_EN adds a dropped-pixel counter on the top.
package frame_wr_pkg;

    localparam int MEM_DW = 256;
    localparam int MEM_AW = 28;
    localparam int PIX_W  = 24;
    localparam int LANES  = 8;
    localparam int LANE_W = MEM_DW / LANES;
    localparam int OFF_W  = 17;

    typedef enum logic {
        IDLE,
        CAPTURE
    } cap_state_t;

    typedef struct packed {
        logic [OFF_W-1:0]  off;
        logic [MEM_DW-1:0] data;
    } fifo_ent_t;

    function automatic logic [LANE_W-1:0] lane_pad(input logic [PIX_W-1:0] p);
        return {{(LANE_W-PIX_W){1'b0}}, p};
    endfunction

endpackage

// File: rtl/frame_wr_if.sv
// Word-wide memory request bus shared with the display read path.
// rw is driven low by the writer; last_addr_update marks the final word.
interface frame_wr_if;
    import frame_wr_pkg::*;

    logic              mem_valid_data;
    logic              mem_ready_data;
    logic              mem_rw_data;
    logic [MEM_AW-1:0] mem_data_addr;
    logic [MEM_DW-1:0] data_wr;
    logic              last_addr_update;

    modport master (
        output mem_valid_data,
        output mem_rw_data,
        output mem_data_addr,
        output data_wr,
        output last_addr_update,
        input  mem_ready_data
    );

    modport slave (
        input  mem_valid_data,
        input  mem_rw_data,
        input  mem_data_addr,
        input  data_wr,
        input  last_addr_update,
        output mem_ready_data
    );

endinterface

// File: rtl/frame_wr_fifo.sv
// Two-entry FIFO of {word offset, packed word}.
// A push while full is taken only if the head is popped on the same edge.
module frame_wr_fifo
    import frame_wr_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  fifo_ent_t din,
    input  logic      pop,
    output fifo_ent_t dout,
    output logic      full,
    output logic      empty
);

    fifo_ent_t  ent [2];
    logic       wp;
    logic       rp;
    logic [1:0] cnt;
    logic       do_pop;
    logic       do_push;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = ent[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent[0] <= '0;
            ent[1] <= '0;
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                ent[wp] <= din;
                wp      <= ~wp;
            end
            if (do_pop) begin
                rp <= ~rp;
            end
            cnt <= cnt + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/frame_writer.sv
// Packs a 24-bit pixel stream eight to a word and writes frames to memory.
// Define FRAME_WR_DROP_CNT_EN to add the drop_cnt output.
module frame_writer
    import frame_wr_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_on,
    input  logic [MEM_AW-1:0] mem_start,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [PIX_W-1:0]  pix_rgb,
    frame_wr_if.master        mem,
    output logic              overflow,
`ifdef FRAME_WR_DROP_CNT_EN
    output logic [15:0]       drop_cnt,
`endif
    output logic              sync_err
);

    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE / LANES;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(FRAME_WORDS - 1);

    cap_state_t       state;
    cap_state_t       state_n;
    logic [2:0]       lane;
    logic [2:0]       lane_n;
    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] off_n;
    logic [PIX_W-1:0] lbuf [LANES-1];

    logic             take;
    logic [2:0]       take_lane;
    logic             word_done;
    logic             sync_hit;
    logic [MEM_DW-1:0] word;

    fifo_ent_t        head;
    logic             full;
    logic             empty;
    logic             pop;
    logic             drop;
    logic             lau_q;

    // {off, lane} is the pixel counter; a sof with it nonzero is mid-frame
    always_comb begin
        state_n   = state;
        lane_n    = lane;
        off_n     = off;
        take      = 1'b0;
        take_lane = lane;
        word_done = 1'b0;
        sync_hit  = 1'b0;
        if (pix_valid) begin
            unique case (state)
                IDLE: begin
                    if (pix_sof && capture_on) begin
                        state_n   = CAPTURE;
                        take      = 1'b1;
                        take_lane = 3'd0;
                        lane_n    = 3'd1;
                        off_n     = '0;
                    end
                end
                CAPTURE: begin
                    if (pix_sof && (lane != 3'd0 || off != '0)) begin
                        sync_hit = 1'b1;
                        off_n    = '0;
                        if (capture_on) begin
                            take      = 1'b1;
                            take_lane = 3'd0;
                            lane_n    = 3'd1;
                        end else begin
                            state_n = IDLE;
                            lane_n  = 3'd0;
                        end
                    end else begin
                        take   = 1'b1;
                        lane_n = lane + 3'd1;
                        if (lane == 3'd7) begin
                            word_done = 1'b1;
                            off_n     = off + 17'd1;
                            if (off == LAST_OFF) begin
                                state_n = IDLE;
                                off_n   = '0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            lane  <= 3'd0;
            off   <= '0;
            for (int k = 0; k < LANES - 1; k++) begin
                lbuf[k] <= '0;
            end
        end else begin
            state <= state_n;
            lane  <= lane_n;
            off   <= off_n;
            if (take && take_lane != 3'd7) begin
                lbuf[take_lane] <= pix_rgb;
            end
        end
    end

    // lane 7 is taken straight from the input on the completing pixel
    always_comb begin
        word = '0;
        for (int k = 0; k < LANES - 1; k++) begin
            word[k*LANE_W +: LANE_W] = lane_pad(lbuf[k]);
        end
        word[(LANES-1)*LANE_W +: LANE_W] = lane_pad(pix_rgb);
    end

    assign pop  = ~empty & mem.mem_ready_data;
    assign drop = word_done & full & ~pop;

    frame_wr_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (word_done),
        .din   ('{off: off, data: word}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign mem.mem_valid_data   = ~empty;
    assign mem.mem_rw_data      = 1'b0;
    assign mem.mem_data_addr    = empty ? '0 : mem_start + MEM_AW'(head.off);
    assign mem.data_wr          = head.data;
    assign mem.last_addr_update = lau_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lau_q    <= 1'b0;
            overflow <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            lau_q <= pop & (head.off == LAST_OFF);
            if (drop) begin
                overflow <= 1'b1;
            end
            if (sync_hit) begin
                sync_err <= 1'b1;
            end
        end
    end

`ifdef FRAME_WR_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= 16'd0;
        end else if (drop) begin
            drop_cnt <= (drop_cnt > 16'hFFF7) ? 16'hFFFF : drop_cnt + 16'd8;
        end
    end
`endif

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer with a 16x2 frame (four words).
// Checks addresses, packing, backpressure, drops, resync and reset.
module tb_frame_writer;

    logic        clk;
    logic        rst_n;
    logic        capture_on;
    logic [27:0] mem_start;
    logic        pix_valid;
    logic        pix_sof;
    logic [23:0] pix_rgb;
    logic        overflow;
    logic        sync_err;
`ifdef FRAME_WR_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int checks;
    int errors;

    frame_wr_if mif ();

    frame_writer #(.H_ACTIVE(16), .V_ACTIVE(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture_on (capture_on),
        .mem_start  (mem_start),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_rgb    (pix_rgb),
        .mem        (mif),
        .overflow   (overflow),
`ifdef FRAME_WR_DROP_CNT_EN
        .drop_cnt   (drop_cnt),
`endif
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [27:0]  wa [$];
    logic [255:0] wd [$];
    int           lau_cnt;
    logic [27:0]  lau_addr;
    int           stall_cnt;
    int           stall_bad;
    logic         p_stall;
    logic [27:0]  p_addr;
    logic [255:0] p_data;

    // Log handshakes and watch held requests on the falling edge
    always @(negedge clk) begin
        if (!rst_n) begin
            wa.delete();
            wd.delete();
            lau_cnt   <= 0;
            lau_addr  <= '0;
            stall_cnt <= 0;
            stall_bad <= 0;
            p_stall   <= 1'b0;
            p_addr    <= '0;
            p_data    <= '0;
        end else begin
            if (mif.last_addr_update) begin
                lau_cnt  <= lau_cnt + 1;
                lau_addr <= (wa.size() > 0) ? wa[wa.size()-1] : 28'hFFFFFFF;
            end
            if (p_stall && (!mif.mem_valid_data || mif.mem_data_addr != p_addr
                            || mif.data_wr != p_data))
                stall_bad <= stall_bad + 1;
            if (mif.mem_valid_data && !mif.mem_ready_data)
                stall_cnt <= stall_cnt + 1;
            p_stall <= mif.mem_valid_data && !mif.mem_ready_data;
            p_addr  <= mif.mem_data_addr;
            p_data  <= mif.data_wr;
            if (mif.mem_valid_data && mif.mem_ready_data) begin
                wa.push_back(mif.mem_data_addr);
                wd.push_back(mif.data_wr);
            end
        end
    end

    function automatic logic [255:0] exp_word(int base, int w);
        logic [255:0] r;
        r = '0;
        for (int k = 0; k < 8; k++)
            r[k*32 +: 32] = {8'h00, 24'(base + 8*w + k)};
        return r;
    endfunction

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(logic sof, logic [23:0] v);
        pix_valid = 1'b1;
        pix_sof   = sof;
        pix_rgb   = v;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic send_frame(int base, int n);
        for (int i = 0; i < n; i++)
            send(i == 0, 24'(base + i));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        pix_valid  = 1'b0;
        pix_sof    = 1'b0;
        pix_rgb    = '0;
        capture_on = 1'b1;
        mem_start  = 28'h100;
        mif.mem_ready_data = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic chk_frame(string nm, int first, int base);
        for (int i = 0; i < 4; i++) begin
            if (first + i < wa.size()) begin
                checks++;
                if (wa[first+i] !== 28'h100 + 28'(i)) begin
                    errors++;
                    $display("FAIL %s_addr%0d: got %h want %h", nm, i,
                             wa[first+i], 28'h100 + 28'(i));
                end
                checks++;
                if (wd[first+i] !== exp_word(base, i)) begin
                    errors++;
                    $display("FAIL %s_data%0d: got %h want %h", nm, i,
                             wd[first+i], exp_word(base, i));
                end
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (mif.mem_valid_data !== 1'b0 || mif.mem_rw_data !== 1'b0
            || mif.last_addr_update !== 1'b0 || overflow !== 1'b0
            || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got v%b rw%b l%b o%b s%b want all 0",
                     mif.mem_valid_data, mif.mem_rw_data,
                     mif.last_addr_update, overflow, sync_err);
        end
        checks++;
        if (mif.mem_data_addr !== 28'h0 || mif.data_wr !== 256'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr %h data %h want 0",
                     mif.mem_data_addr, mif.data_wr);
        end
`ifdef FRAME_WR_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt);
        end
`endif
    endtask

    task automatic test_basic_frame();
        do_reset();
        for (int i = 0; i < 7; i++) send(i == 0, 24'(i));
        checks++;
        if (mif.mem_valid_data !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: got %b want 0", mif.mem_valid_data);
        end
        send(1'b0, 24'd7);
        checks++;
        if (mif.mem_valid_data !== 1'b1 || mif.mem_data_addr !== 28'h100) begin
            errors++;
            $display("FAIL basic_latency: got v%b addr %h want v1 addr 100",
                     mif.mem_valid_data, mif.mem_data_addr);
        end
        for (int i = 8; i < 32; i++) send(1'b0, 24'(i));
        tick(6);
        checks++;
        if (wa.size() != 4) begin
            errors++;
            $display("FAIL basic_count: got %0d want 4", wa.size());
        end
        chk_frame("basic", 0, 0);
        if (wd.size() > 0) begin
            checks++;
            if (wd[0][31:0] !== 32'h0 || wd[0][255:224] !== 32'h7) begin
                errors++;
                $display("FAIL basic_lanes: got l0 %h l7 %h want 0 and 7",
                         wd[0][31:0], wd[0][255:224]);
            end
        end
        checks++;
        if (lau_cnt != 1 || lau_addr !== 28'h103) begin
            errors++;
            $display("FAIL basic_last: got %0d pulses after %h want 1 after 103",
                     lau_cnt, lau_addr);
        end
        checks++;
        if (overflow !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_flags: got o%b s%b want 0 0", overflow, sync_err);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        mif.mem_ready_data = 1'b0;
        send_frame(0, 32);
        tick(8);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b want 1", overflow);
        end
        checks++;
        if (mif.mem_valid_data !== 1'b1 || mif.mem_data_addr !== 28'h100
            || mif.data_wr !== exp_word(0, 0)) begin
            errors++;
            $display("FAIL ovf_hold: got v%b addr %h want v1 addr 100 word0",
                     mif.mem_valid_data, mif.mem_data_addr);
        end
`ifdef FRAME_WR_DROP_CNT_EN
        checks++;
        if (drop_cnt !== 16'd16) begin
            errors++;
            $display("FAIL ovf_drop_cnt: got %0d want 16", drop_cnt);
        end
`endif
        mif.mem_ready_data = 1'b1;
        tick(6);
        checks++;
        if (wa.size() != 2) begin
            errors++;
            $display("FAIL ovf_count: got %0d want 2", wa.size());
        end
        chk_frame("ovf", 0, 0);
        checks++;
        if (lau_cnt != 0) begin
            errors++;
            $display("FAIL ovf_last: got %0d pulses want 0", lau_cnt);
        end
    endtask

    task automatic test_resync();
        do_reset();
        send_frame(24'h10, 12);
        send_frame(24'h40, 32);
        tick(6);
        checks++;
        if (sync_err !== 1'b1) begin
            errors++;
            $display("FAIL sync_flag: got %b want 1", sync_err);
        end
        checks++;
        if (wa.size() != 5) begin
            errors++;
            $display("FAIL sync_count: got %0d want 5", wa.size());
        end
        if (wa.size() > 0) begin
            checks++;
            if (wa[0] !== 28'h100 || wd[0] !== exp_word(24'h10, 0)) begin
                errors++;
                $display("FAIL sync_old_word: got %h %h want 100 %h",
                         wa[0], wd[0], exp_word(24'h10, 0));
            end
        end
        chk_frame("sync", 1, 24'h40);
        checks++;
        if (lau_cnt != 1) begin
            errors++;
            $display("FAIL sync_last: got %0d pulses want 1", lau_cnt);
        end
    endtask

    task automatic test_capture_off();
        do_reset();
        capture_on = 1'b0;
        send_frame(24'h20, 32);
        tick(4);
        checks++;
        if (wa.size() != 0 || mif.mem_valid_data !== 1'b0) begin
            errors++;
            $display("FAIL off_writes: got %0d writes v%b want 0 v0",
                     wa.size(), mif.mem_valid_data);
        end
        capture_on = 1'b1;
        send_frame(24'h60, 32);
        tick(6);
        checks++;
        if (wa.size() != 4) begin
            errors++;
            $display("FAIL on_count: got %0d want 4", wa.size());
        end
        chk_frame("on", 0, 24'h60);
    endtask

    task automatic test_ready_toggle();
        do_reset();
        mif.mem_ready_data = 1'b0;
        fork
            send_frame(24'h200, 32);
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    mif.mem_ready_data = ~mif.mem_ready_data;
                end
            end
        join
        mif.mem_ready_data = 1'b1;
        tick(6);
        checks++;
        if (wa.size() != 4) begin
            errors++;
            $display("FAIL tog_count: got %0d want 4", wa.size());
        end
        chk_frame("tog", 0, 24'h200);
        checks++;
        if (stall_cnt == 0) begin
            errors++;
            $display("FAIL tog_stalls: got %0d want >0", stall_cnt);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL tog_stable: got %0d changes want 0", stall_bad);
        end
        checks++;
        if (lau_cnt != 1) begin
            errors++;
            $display("FAIL tog_last: got %0d pulses want 1", lau_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mif.mem_ready_data = 1'b0;
        send_frame(24'hA0, 20);
        checks++;
        if (mif.mem_valid_data !== 1'b1) begin
            errors++;
            $display("FAIL rstm_pre_valid: got %b want 1", mif.mem_valid_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mif.mem_valid_data !== 1'b0 || mif.mem_data_addr !== 28'h0
            || mif.data_wr !== 256'h0 || mif.last_addr_update !== 1'b0
            || overflow !== 1'b0 || sync_err !== 1'b0) begin
            errors++;
            $display("FAIL rstm_outputs: got v%b addr %h data %h want all 0",
                     mif.mem_valid_data, mif.mem_data_addr, mif.data_wr);
        end
        tick(2);
        rst_n = 1'b1;
        mif.mem_ready_data = 1'b1;
        tick(1);
        send_frame(24'hC0, 32);
        tick(6);
        checks++;
        if (wa.size() != 4) begin
            errors++;
            $display("FAIL rstm_count: got %0d want 4", wa.size());
        end
        chk_frame("rstm", 0, 24'hC0);
        checks++;
        if (lau_cnt != 1) begin
            errors++;
            $display("FAIL rstm_last: got %0d pulses want 1", lau_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_frame();
        test_overflow();
        test_resync();
        test_capture_off();
        test_ready_toggle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
